// File: rtl/invaders_grid_if.sv
// Formation controller bundle: game-side inputs (start, level, bullet) and formation state outputs.
// Latency: pure wiring; every output is driven by a register inside invaders_grid.
// Backpressure: none; the inputs are level signals sampled on every clock.
interface invaders_grid_if #(
    parameter int ROWS = 4,
    parameter int COLS = 5,
    parameter int X_W  = 5,
    parameter int Y_W  = 4
);
    localparam int N   = ROWS * COLS;
    localparam int A_W = $clog2(N + 1);

    // controls and bullet coming from the game top level / player
    logic             start;
    logic [1:0]       level;
    logic [X_W-1:0]   bullet_x;
    logic [Y_W-1:0]   bullet_y;
    logic             bullet_flying;

    // formation state going to sprite_drawer / player
    logic             hit;
    logic [N-1:0]     invaders_array;
    logic [X_W-1:0]   invaders_x;
    logic [Y_W-1:0]   invaders_line;
    logic [A_W-1:0]   alive_count;
    logic             cleared;
    logic             landed;

    modport master (
        output start, level, bullet_x, bullet_y, bullet_flying,
        input  hit, invaders_array, invaders_x, invaders_line, alive_count, cleared, landed
    );

    modport slave (
        input  start, level, bullet_x, bullet_y, bullet_flying,
        output hit, invaders_array, invaders_x, invaders_line, alive_count, cleared, landed
    );
endinterface

// File: rtl/invaders_grid.sv
// Invader formation: marches/steps down, kills on bullet hit, flags cleared/landed (SPEEDUP_EN: faster march when few remain).
// Latency: one cycle from bullet-in-cell to hit pulse; one step per march period.
// Backpressure: none; one kill per bullet, re-armed when bullet_flying drops.
module invaders_grid #(
    parameter int ROWS      = 4,
    parameter int COLS      = 5,
    parameter int X_W       = 5,
    parameter int Y_W       = 4,
    parameter int FIELD_W   = 20,
    parameter int LAND_LINE = 13,
    parameter int TICK_DIV  = 9000000
) (
    input  logic              clk_36MHz,
    input  logic              reset,
    invaders_grid_if.slave    bus
);
    localparam int N     = ROWS * COLS;
    localparam int A_W   = $clog2(N + 1);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(TICK_DIV + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARCH,
        S_CLEARED,
        S_LANDED
    } state_t;

    state_t           r_state,   w_state_nxt;
    logic [N-1:0]     r_array,   w_array_nxt;
    logic [X_W-1:0]   r_x,       w_x_nxt;
    logic [Y_W-1:0]   r_line,    w_line_nxt;
    logic             r_left,    w_left_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [A_W-1:0]   r_alive,   w_alive_nxt;
    logic             r_hit,     w_hit_nxt;
    logic             r_arm,     w_arm_nxt;
    logic             r_cleared, w_cleared_nxt;
    logic             r_landed,  w_landed_nxt;

    logic [CNT_W-1:0] w_period;
    logic             w_tick;
    logic [X_W-1:0]   w_col;
    logic [Y_W-1:0]   w_row;
    logic [IDX_W-1:0] w_idx;
    logic             w_candidate;
    logic [X_W-1:0]   w_x_step;
    logic [Y_W-1:0]   w_line_step;
    logic             w_left_step;
    logic             w_land_step;

    // march period from level (and survivor count when speedup is built in); never below one cycle
    always_comb begin
        w_period = CNT_W'(TICK_DIV) >> bus.level;
`ifdef SPEEDUP_EN
        if (r_alive == A_W'(1)) begin
            w_period = w_period >> 2;
        end else if (r_alive <= A_W'(N / 4)) begin
            w_period = w_period >> 1;
        end
`endif
        if (w_period == '0) begin
            w_period = CNT_W'(1);
        end
    end

    // a counter already at or past the terminal count (e.g. after a level change) fires at once
    assign w_tick = (r_cnt >= (w_period - CNT_W'(1)));

    // bullet position relative to the formation origin; wraps so left/above lands out of range
    always_comb begin
        w_col       = bus.bullet_x - r_x;
        w_row       = bus.bullet_y - r_line;
        w_idx       = IDX_W'(int'(w_row) * COLS + int'(w_col));
        w_candidate = 1'b0;
        if ((r_state == S_MARCH) && bus.bullet_flying && r_arm &&
            (int'(w_col) < COLS) && (int'(w_row) < ROWS)) begin
            w_candidate = r_array[w_idx];
        end
    end

    // next formation position for a tick; edges use the full width, dead columns included
    always_comb begin
        w_x_step    = r_x;
        w_line_step = r_line;
        w_left_step = r_left;
        if (!r_left) begin
            if (int'(r_x) == FIELD_W - COLS) begin
                w_line_step = r_line + Y_W'(1);
                w_left_step = 1'b1;
            end else begin
                w_x_step = r_x + X_W'(1);
            end
        end else begin
            if (r_x == '0) begin
                w_line_step = r_line + Y_W'(1);
                w_left_step = 1'b0;
            end else begin
                w_x_step = r_x - X_W'(1);
            end
        end
        w_land_step = ((int'(w_line_step) + ROWS - 1) == LAND_LINE);
    end

    // next-state and next-value logic; start overrides everything, including a coincident hit
    always_comb begin
        w_state_nxt   = r_state;
        w_array_nxt   = r_array;
        w_x_nxt       = r_x;
        w_line_nxt    = r_line;
        w_left_nxt    = r_left;
        w_cnt_nxt     = r_cnt;
        w_alive_nxt   = r_alive;
        w_hit_nxt     = 1'b0;
        w_arm_nxt     = r_arm;
        w_cleared_nxt = r_cleared;
        w_landed_nxt  = r_landed;

        if (!bus.bullet_flying) begin
            w_arm_nxt = 1'b1;
        end

        if (bus.start) begin
            w_state_nxt   = S_MARCH;
            w_array_nxt   = '1;
            w_x_nxt       = '0;
            w_line_nxt    = '0;
            w_left_nxt    = 1'b0;
            w_cnt_nxt     = '0;
            w_alive_nxt   = A_W'(N);
            w_cleared_nxt = 1'b0;
            w_landed_nxt  = 1'b0;
            w_arm_nxt     = 1'b1;
        end else begin
            case (r_state)
                S_MARCH: begin
                    w_cnt_nxt = w_tick ? '0 : (r_cnt + CNT_W'(1));
                    if (w_tick) begin
                        w_x_nxt    = w_x_step;
                        w_line_nxt = w_line_step;
                        w_left_nxt = w_left_step;
                    end
                    if (w_candidate) begin
                        w_array_nxt[w_idx] = 1'b0;
                        w_alive_nxt        = r_alive - A_W'(1);
                        w_hit_nxt          = 1'b1;
                        w_arm_nxt          = 1'b0;
                    end
                    // last kill beats a landing step in the same cycle
                    if (w_candidate && (r_alive == A_W'(1))) begin
                        w_state_nxt   = S_CLEARED;
                        w_cleared_nxt = 1'b1;
                    end else if (w_tick && w_land_step) begin
                        w_state_nxt  = S_LANDED;
                        w_landed_nxt = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // state registers with asynchronous reset back to a full, parked formation
    always_ff @(posedge clk_36MHz or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_array   <= '1;
            r_x       <= '0;
            r_line    <= '0;
            r_left    <= 1'b0;
            r_cnt     <= '0;
            r_alive   <= A_W'(N);
            r_hit     <= 1'b0;
            r_arm     <= 1'b1;
            r_cleared <= 1'b0;
            r_landed  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_array   <= w_array_nxt;
            r_x       <= w_x_nxt;
            r_line    <= w_line_nxt;
            r_left    <= w_left_nxt;
            r_cnt     <= w_cnt_nxt;
            r_alive   <= w_alive_nxt;
            r_hit     <= w_hit_nxt;
            r_arm     <= w_arm_nxt;
            r_cleared <= w_cleared_nxt;
            r_landed  <= w_landed_nxt;
        end
    end

    assign bus.hit            = r_hit;
    assign bus.invaders_array = r_array;
    assign bus.invaders_x     = r_x;
    assign bus.invaders_line  = r_line;
    assign bus.alive_count    = r_alive;
    assign bus.cleared        = r_cleared;
    assign bus.landed         = r_landed;
endmodule

// File: tb/tb_invaders_grid.sv
// Bench for invaders_grid: reference model pushes expected output snapshots, negedge monitor pops and compares.
// Latency: one snapshot per clock edge (and one on asynchronous reset).
// Backpressure: none; stimulus is driven 1 ns after each rising edge.
module tb_invaders_grid;
    localparam int ROWS = 4, COLS = 5, X_W = 5, Y_W = 4;
    localparam int FIELD_W = 20, LAND_LINE = 13, TICK_DIV = 16;
    localparam int N = ROWS * COLS;
    localparam int A_W = $clog2(N + 1);
    localparam int M_IDLE = 0, M_MARCH = 1, M_CLR = 2, M_LAND = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    invaders_grid_if #(.ROWS(ROWS), .COLS(COLS), .X_W(X_W), .Y_W(Y_W)) bus ();

    invaders_grid #(
        .ROWS(ROWS), .COLS(COLS), .X_W(X_W), .Y_W(Y_W),
        .FIELD_W(FIELD_W), .LAND_LINE(LAND_LINE), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk_36MHz(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           hit;
        logic [N-1:0]   arr;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] line;
        logic [A_W-1:0] alive;
        logic           cleared;
        logic           landed;
    } snap_t;

    snap_t exp_q[$];
    snap_t mon_e, mon_a;
    int n_checks = 0;
    int n_pass = 0;

    // reference model: grid of alive flags, integer position, direction +1/-1
    int m_state, mx, mline, mdir, mcnt;
    bit m_al[ROWS][COLS];
    bit marm, mhit;

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                n += m_al[r][c];
        return n;
    endfunction

    function automatic snap_t m_snap();
        snap_t s;
        s.hit = mhit;
        s.arr = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                s.arr[r*COLS+c] = m_al[r][c];
        s.x       = X_W'(mx);
        s.line    = Y_W'(mline);
        s.alive   = A_W'(m_count());
        s.cleared = (m_state == M_CLR);
        s.landed  = (m_state == M_LAND);
        return s;
    endfunction

    task automatic m_load(input int st);
        m_state = st;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_al[r][c] = 1'b1;
        mx = 0; mline = 0; mdir = 1; mcnt = 0; marm = 1'b1; mhit = 1'b0;
    endtask

    task automatic m_step();
        int p, col, row, alive_before;
        bit tick, kill;
        bit fly;
        fly = bus.bullet_flying;
        if (bus.start) begin
            m_load(M_MARCH);
            return;
        end
        mhit = 1'b0;
        if (m_state != M_MARCH) begin
            if (!fly) marm = 1'b1;
            return;
        end
        alive_before = m_count();
        p = TICK_DIV >> bus.level;
`ifdef SPEEDUP_EN
        if (alive_before == 1) p = p >> 2;
        else if (alive_before <= N / 4) p = p >> 1;
`endif
        if (p < 1) p = 1;
        tick = (mcnt >= p - 1);
        mcnt = tick ? 0 : mcnt + 1;
        col = (int'(bus.bullet_x) - mx) & ((1 << X_W) - 1);
        row = (int'(bus.bullet_y) - mline) & ((1 << Y_W) - 1);
        kill = fly && marm && col < COLS && row < ROWS && m_al[row][col];
        if (kill) begin
            m_al[row][col] = 1'b0;
            mhit = 1'b1;
        end
        if (tick) begin
            if ((mdir > 0 && mx + COLS - 1 == FIELD_W - 1) || (mdir < 0 && mx == 0)) begin
                mline = mline + 1;
                mdir = -mdir;
            end else begin
                mx = mx + mdir;
            end
        end
        if (!fly) marm = 1'b1;
        else if (kill) marm = 1'b0;
        if (m_count() == 0) m_state = M_CLR;
        else if (tick && mline + ROWS - 1 == LAND_LINE) m_state = M_LAND;
    endtask

    // model advances on every edge; an asynchronous reset discards the pending snapshot
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_load(M_IDLE);
            exp_q.delete();
        end else begin
            m_step();
        end
        exp_q.push_back(m_snap());
    end

    // monitor: compare the DUT's registered outputs against the oldest expected snapshot
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a.hit = bus.hit; mon_a.arr = bus.invaders_array; mon_a.x = bus.invaders_x;
            mon_a.line = bus.invaders_line; mon_a.alive = bus.alive_count;
            mon_a.cleared = bus.cleared; mon_a.landed = bus.landed;
            n_checks++;
            if (mon_a === mon_e) n_pass++;
            else $display("FAIL snapshot t=%0t actual hit=%b arr=%h x=%0d line=%0d alive=%0d clr=%b land=%b required hit=%b arr=%h x=%0d line=%0d alive=%0d clr=%b land=%b",
                          $time, mon_a.hit, mon_a.arr, mon_a.x, mon_a.line, mon_a.alive, mon_a.cleared, mon_a.landed,
                          mon_e.hit, mon_e.arr, mon_e.x, mon_e.line, mon_e.alive, mon_e.cleared, mon_e.landed);
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic aim(input int c, input int r);
        bus.bullet_x = X_W'(mx + c);
        bus.bullet_y = Y_W'(mline + r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sx, sline, guard;
        bus.start = 1'b0; bus.level = 2'd0; bus.bullet_x = '0; bus.bullet_y = '0; bus.bullet_flying = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check("reset_alive", bus.alive_count, 20);
        check("reset_array", bus.invaders_array, 20'hFFFFF);
        cyc(20);
        check("idle_no_march", bus.invaders_x, 0);

        // march right across the field, turn at the edge, then walk back
        pulse_start();
        cyc(240);
        check("x_at_right_edge", bus.invaders_x, 15);
        check("line_before_turn", bus.invaders_line, 0);
        cyc(16);
        check("line_after_turn", bus.invaders_line, 1);
        check("x_held_on_turn", bus.invaders_x, 15);
        cyc(16);
        check("x_after_turn", bus.invaders_x, 14);

        // single kill at x=3, line 0, then no repeat kills
        pulse_start();
        cyc(48);
        check("x_before_hit", bus.invaders_x, 3);
        bus.bullet_x = 5'd5; bus.bullet_y = 4'd2; bus.bullet_flying = 1'b1;
        cyc(1);
        check("hit_pulse", bus.hit, 1);
        check("bit12_cleared", bus.invaders_array[12], 0);
        check("alive_19", bus.alive_count, 19);
        cyc(1);
        check("hit_one_cycle", bus.hit, 0);
        cyc(5);
        check("no_second_hit", bus.alive_count, 19);
        bus.bullet_flying = 1'b0;
        cyc(1);
        aim(2, 2);
        bus.bullet_flying = 1'b1;
        cyc(3);
        check("dead_cell_no_hit", bus.alive_count, 19);

        // kill everything that is left
        bus.bullet_flying = 1'b0;
        cyc(1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (m_al[r][c]) begin
                    aim(c, r);
                    bus.bullet_flying = 1'b1;
                    cyc(1);
                    bus.bullet_flying = 1'b0;
                    if (r != ROWS-1 || c != COLS-1) cyc(1);
                end
        check("last_hit", bus.hit, 1);
        check("cleared", bus.cleared, 1);
        check("alive_0", bus.alive_count, 0);
        sx = bus.invaders_x; sline = bus.invaders_line;
        cyc(40);
        check("cleared_x_frozen", bus.invaders_x, sx);
        check("cleared_line_frozen", bus.invaders_line, sline);
        pulse_start();
        check("reload_array", bus.invaders_array, 20'hFFFFF);
        check("reload_cleared", bus.cleared, 0);

        // landing at level 2 without any bullets
        bus.level = 2'd2;
        pulse_start();
        guard = 0;
        while (m_state != M_LAND && guard < 3000) begin
            cyc(1);
            guard++;
        end
        check("land_within_budget", guard < 3000, 1);
        check("landed", bus.landed, 1);
        check("land_line", bus.invaders_line, 10);
        sx = bus.invaders_x;
        cyc(20);
        check("landed_frozen", bus.invaders_x, sx);

        // randomized play: level changes, bullets around the formation, occasional restarts
        pulse_start();
        for (int i = 0; i < 2500; i++) begin
            if (i % 60 == 0) bus.level = 2'($urandom_range(0, 3));
            bus.bullet_x = X_W'(mx + int'($urandom_range(0, COLS + 1)) - 1);
            bus.bullet_y = Y_W'(mline + int'($urandom_range(0, ROWS + 1)) - 1);
            bus.bullet_flying = ($urandom_range(0, 9) < 6);
            bus.start = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        bus.start = 1'b0; bus.bullet_flying = 1'b0; bus.level = 2'd0;
        cyc(2);

        // reset in the middle of a count
        pulse_start();
        cyc(10);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_count_x", bus.invaders_x, 0);
        check("rst_mid_count_alive", bus.alive_count, 20);
        cyc(1);
        reset = 1'b0;
        cyc(40);
        check("no_march_after_reset", bus.invaders_x, 0);

        // reset while a hit candidate is present
        pulse_start();
        aim(0, 0);
        bus.bullet_flying = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_hit_hit", bus.hit, 0);
        check("rst_mid_hit_alive", bus.alive_count, 20);
        cyc(1);
        reset = 1'b0;
        cyc(5);
        check("idle_no_hit", bus.alive_count, 20);
        bus.bullet_flying = 1'b0;
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/invaders_grid.md
Name: invaders_grid

Overview:
- Parametrised invader formation controller: ROWS x COLS grid of invaders.
- Marches left/right across the playfield and steps down one line at each edge.
- Detects bullet hits, tracks survivors, and flags wave-cleared and landed conditions.
- Feeds sprite_drawer (array, position) and player (hit) in the game top level; speed scales with level.

Parameters:
- ROWS, 4, formation rows.
- COLS, 5, formation columns.
- X_W, 5, width of column coordinates (bullet_x, invaders_x).
- Y_W, 4, width of line coordinates (bullet_y, invaders_line).
- FIELD_W, 20, playfield width in columns; rightmost column is FIELD_W-1.
- LAND_LINE, 13, line at which the bottom formation row counts as landed.
- TICK_DIV, 9000000, clk_36MHz cycles per march step at level 0; must be ≥ 16.

Ports:
- clk_36MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: load full formation and begin marching.
- level  in  2  speed level; march period = TICK_DIV >> level.
- bullet_x  in  X_W  bullet column.
- bullet_y  in  Y_W  bullet line.
- bullet_flying  in  1  bullet active.
- hit  out  1  one-cycle pulse on a kill.
- invaders_array  out  ROWS*COLS  alive bits; bit r*COLS+c is row r, column c; row 0 is the top row.
- invaders_x  out  X_W  column of the formation's left edge.
- invaders_line  out  Y_W  line of the formation's top row.
- alive_count  out  $clog2(ROWS*COLS+1)  number of set bits in invaders_array.
- cleared  out  1  wave destroyed; level.
- landed  out  1  formation reached LAND_LINE; level.

Behaviour:
- Reset (async, any time, including mid-step):
  - State IDLE; invaders_array all ones; alive_count = ROWS*COLS.
  - invaders_x = 0, invaders_line = 0, direction = right.
  - Step counter 0; hit, cleared, landed = 0; hit-arm = 1.
- States:
  - IDLE: no marching, no hits. start -> MARCH.
  - MARCH: counter runs; hits evaluated.
    - alive_count reaches 0 -> CLEARED.
    - invaders_line + ROWS - 1 == LAND_LINE after a step -> LANDED.
    - If both hold in the same cycle, CLEARED wins.
  - CLEARED: cleared = 1, formation frozen.
  - LANDED: landed = 1, formation frozen.
  - start in any state: reload all ones, x = 0, line = 0, direction right, counter 0, clear flags, hit-arm = 1, enter MARCH next cycle.
- Step counter:
  - Counts 0 .. (TICK_DIV >> level) - 1; the tick fires on the terminal count, then the counter wraps to 0.
  - level is sampled continuously; if the counter is ≥ the new period, the tick fires next cycle.
- On tick:
  - Right and invaders_x + COLS - 1 == FIELD_W - 1: line + 1, direction = left, x unchanged.
  - Left and invaders_x == 0: line + 1, direction = right, x unchanged.
  - Otherwise x ± 1.
  - Edges use the full formation width, including dead columns.
- Hit detection (MARCH only):
  - col = bullet_x - invaders_x; row = bullet_y - invaders_line, both unsigned with wrap.
  - Candidate when col < COLS, row < ROWS, bullet_flying = 1, hit-arm = 1, and bit row*COLS+col is set.
  - Next cycle: bit cleared, alive_count - 1, hit = 1 for one cycle, hit-arm = 0.
  - hit-arm returns to 1 when bullet_flying = 0; one kill per bullet.
  - Hit uses the pre-step position when it coincides with a tick; both take effect in the same cycle.
  - start coincident with a candidate: start wins, no hit.
- alive_count: maintained by decrement; must always equal popcount(invaders_array).
- All outputs registered.

Optional Feature:
- SPEEDUP_EN defined:
  - When alive_count ≤ (ROWS*COLS)/4, the march period = (TICK_DIV >> level) >> 1.
  - When alive_count == 1, the period = (TICK_DIV >> level) >> 2.
- Undefined: the period depends on level only.

Test Plan:
- Bench settings: TICK_DIV=16, defaults otherwise.
- Reset then start, level 0: x steps 0→15 at one step per 16 cycles. Next tick: line 0→1, x stays 15, direction left. Then x decrements.
- At x=3, line=0: bullet_x=5, bullet_y=2, flying=1 -> hit pulse exactly one cycle; bit 2*5+2=12 cleared; alive_count 20→19. Holding flying=1 gives no second hit; drop and reassert flying at bit 12's location -> no hit.
- Kill all 20 invaders -> cleared=1 on the cycle after the last hit; x and line frozen. start -> array 0xFFFFF, cleared=0, MARCH.
- No hits, level 2 (period 4): march until line 10 (10+3=13) -> landed=1, formation frozen.
- Assert reset mid-count and mid-hit -> all outputs at reset values immediately; no march until start.
- SPEEDUP_EN, level 0, 5 alive -> step period 8 cycles; 1 alive -> period 4.
